// File: rtl/id_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl_pkg
// Description : Shared constants and types for the decode-to-execute issue
//               controller. This includes the register index width, the
//               state encoding and the scoreboard lookup helper.
// Options     : ID_ISSUE_BYPASS_EN (consumed by id_issue_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
package id_issue_ctrl_pkg;

  // Architectural register file geometry (RV64 integer file)
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  // Issue FSM encoding
  localparam logic [1:0] ISSUE_RUN   = 2'd0;
  localparam logic [1:0] ISSUE_DRAIN = 2'd1;
  localparam logic [1:0] ISSUE_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = ISSUE_RUN,
    ST_DRAIN = ISSUE_DRAIN,
    ST_FLUSH = ISSUE_FLUSH
  } issue_state_e;

  // A register access conflicts when it is enabled, is not x0 and that
  // register still has a write pending.
  function automatic logic reg_hit(input logic              ena,
                                   input logic [REG_AW-1:0] addr,
                                   input logic [NREGS-1:0]  busy);
    return ena & (addr != '0) & busy[addr];
  endfunction

endpackage : id_issue_ctrl_pkg
`default_nettype wire

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : id_scoreboard
// Description : 32-entry pending-write scoreboard. One set port is driven by
//               issue and one clear port is driven by writeback. When both
//               ports name the same index in one cycle, the set wins. The
//               module also performs the three-read (rs1/rs2/rd) hazard
//               lookup. Entry x0 never becomes busy.
// Revision    : 1.0 - initial release
// ============================================================================
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [REG_AW-1:0] clr_addr_i,
  input  logic              rs1_en_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic              rs2_en_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              rd_en_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              hazard_o,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector. The clear is applied first so that a set to the same
  // index overrides it. x0 is forced back to zero afterwards.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // RAW on either source, or WAW on the destination
  assign hazard_o = reg_hit(rs1_en_i, rs1_addr_i, busy_q)
                  | reg_hit(rs2_en_i, rs2_addr_i, busy_q)
                  | reg_hit(rd_en_i,  rd_addr_i,  busy_q);

  assign busy_o = busy_q;

endmodule : id_scoreboard
`default_nettype wire

// File: rtl/id_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_issue_ctrl
// Description : Issue controller between decode and execute of the in-order
//               RV64 pipeline. It stalls on RAW/WAW hazards and on a full
//               in-flight window, serialises system/fence instructions by
//               draining the pipe, and squashes decode for one bubble cycle
//               on a redirect.
// Options     : ID_ISSUE_BYPASS_EN - when defined, execute forwarding is
//               assumed. Only loads mark their destination busy. When it is
//               undefined, every issued writer marks its destination busy.
// Revision    : 1.0 - initial release
// ============================================================================
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  output logic              issue_valid,
  input  logic              ex_ready,
  input  logic              rs1_r_ena,
  input  logic [REG_AW-1:0] rs1_r_addr,
  input  logic              rs2_r_ena,
  input  logic [REG_AW-1:0] rs2_r_addr,
  input  logic              rd_w_ena,
  input  logic [REG_AW-1:0] rd_w_addr,
  input  logic              mem_to_reg,
  input  logic              is_serial,
  input  logic              redirect,
  input  logic              wb_valid,
  input  logic              wb_w_ena,
  input  logic [REG_AW-1:0] wb_w_addr,
  output logic              if_flush,
  output logic              stall,
  output logic [CNT_W-1:0]  inflight,
  output logic [NREGS-1:0]  busy_vec
);

  issue_state_e     state_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] inflight_d;

  logic hz;
  logic full;
  logic ser_block;
  logic run;
  logic fire;
  logic retire;
  logic mark;
  logic set_en;

  // --------------------------------------------------------------------------
  // Scoreboard marking policy
  // --------------------------------------------------------------------------
`ifdef ID_ISSUE_BYPASS_EN
  // ALU results are forwarded, so only load results can still be late.
  assign mark = mem_to_reg;
`else
  // Without forwarding, every writer must reach writeback before use.
  logic mem_to_reg_unused;
  assign mem_to_reg_unused = mem_to_reg;
  assign mark              = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Issue decision
  // --------------------------------------------------------------------------
  assign run       = (state_q == ST_RUN);
  assign full      = (inflight_q == CNT_W'(MAX_INFLIGHT));
  assign ser_block = is_serial & (inflight_q != '0);

  // Handshake outputs are held low while reset is asserted.
  assign issue_valid = ~rst & run & id_valid & ~hz & ~full & ~ser_block & ~redirect;
  assign fire        = issue_valid & ex_ready;
  assign id_ready    = ~rst & (fire | redirect | (run & ~id_valid));
  assign if_flush    = ~rst & redirect;
  assign stall       = ~rst & id_valid & ~fire & ~redirect;

  // A retire with nothing in flight is ignored so the counter floors at zero.
  assign retire = wb_valid & (inflight_q != '0);
  assign set_en = fire & rd_w_ena & mark;

  // --------------------------------------------------------------------------
  // Pending-write scoreboard
  // --------------------------------------------------------------------------
  id_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_addr_i (rd_w_addr),
    .clr_en_i   (wb_valid & wb_w_ena),
    .clr_addr_i (wb_w_addr),
    .rs1_en_i   (rs1_r_ena),
    .rs1_addr_i (rs1_r_addr),
    .rs2_en_i   (rs2_r_ena),
    .rs2_addr_i (rs2_r_addr),
    .rd_en_i    (rd_w_ena),
    .rd_addr_i  (rd_w_addr),
    .hazard_o   (hz),
    .busy_o     (busy_vec)
  );

  // --------------------------------------------------------------------------
  // In-flight counter
  // --------------------------------------------------------------------------

  // Next count: an issue and a retire in the same cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    case ({fire, retire})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // In-flight counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------

  // Redirect overrides everything. A serial instruction forces a drain before
  // it issues and holds younger instructions until it retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else if (redirect) begin
      state_q <= ST_FLUSH;
    end else begin
      case (state_q)
        ST_FLUSH: state_q <= ST_RUN;
        ST_RUN: begin
          if ((fire & is_serial) | (id_valid & ser_block)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (inflight_q == '0) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule : id_issue_ctrl
`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_issue_ctrl
// Description : Self-checking bench for id_issue_ctrl. It applies a directed
//               vector table, a forwarding-dependent hand sequence and
//               random traffic, and checks every cycle against a behavioural
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_issue_ctrl;

  localparam int MAXI = 4;
  localparam int CW   = 3;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_ready, issue_valid, ex_ready;
  logic        rs1_r_ena, rs2_r_ena, rd_w_ena, mem_to_reg, is_serial, redirect;
  logic [4:0]  rs1_r_addr, rs2_r_addr, rd_w_addr, wb_w_addr;
  logic        wb_valid, wb_w_ena, if_flush, stall;
  logic [CW-1:0] inflight;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  id_issue_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .issue_valid(issue_valid), .ex_ready(ex_ready),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .mem_to_reg(mem_to_reg), .is_serial(is_serial), .redirect(redirect),
    .wb_valid(wb_valid), .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr),
    .if_flush(if_flush), .stall(stall), .inflight(inflight), .busy_vec(busy_vec)
  );

  typedef struct {
    logic rst, idv, exr, rs1e, rs2e, rde, ld, ser, redir, wbv, wbe;
    logic [4:0] rs1a, rs2a, rda, wba;
  } stim_t;

  typedef struct {
    stim_t s;
    logic [38:0] exp;   // {issue_valid, id_ready, if_flush, stall, inflight, busy_vec}
  } row_t;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: pending-register set, in-flight count, and two mode
  // flags (draining for a serial op, one bubble after a redirect).
  logic [31:0] mb;
  int          mcnt;
  bit          mdrain, mflush;

  function automatic row_t mk(input logic rst_, input logic idv, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic ser,
                              input logic redir, input logic wbv, input logic [4:0] wba,
                              input logic iv, input logic idr, input logic fl, input logic st,
                              input logic [2:0] inf, input logic [31:0] busy);
    row_t r;
    r.s.rst = rst_; r.s.idv = idv; r.s.exr = 1'b1;
    r.s.rs1e = 1'b1; r.s.rs1a = rs1; r.s.rs2e = 1'b1; r.s.rs2a = rs2;
    r.s.rde = 1'b1; r.s.rda = rd; r.s.ld = 1'b1; r.s.ser = ser; r.s.redir = redir;
    r.s.wbv = wbv; r.s.wbe = wbv; r.s.wba = wba;
    r.exp = {iv, idr, fl, st, inf, busy};
    return r;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; id_valid = s.idv; ex_ready = s.exr;
    rs1_r_ena = s.rs1e; rs1_r_addr = s.rs1a; rs2_r_ena = s.rs2e; rs2_r_addr = s.rs2a;
    rd_w_ena = s.rde; rd_w_addr = s.rda; mem_to_reg = s.ld; is_serial = s.ser;
    redirect = s.redir; wb_valid = s.wbv; wb_w_ena = s.wbe; wb_w_addr = s.wba;
  endtask

  task automatic model_eval(input stim_t s, output logic [38:0] e, output bit fire);
    bit run, hz, iv, idr, fl, st;
    run = !mdrain && !mflush;
    hz  = (s.rs1e && s.rs1a != 0 && mb[s.rs1a]) ||
          (s.rs2e && s.rs2a != 0 && mb[s.rs2a]) ||
          (s.rde  && s.rda  != 0 && mb[s.rda]);
    iv   = !s.rst && run && s.idv && !hz && (mcnt < MAXI) &&
           !(s.ser && mcnt != 0) && !s.redir;
    fire = iv && s.exr;
    idr  = !s.rst && (fire || s.redir || (run && !s.idv));
    fl   = !s.rst && s.redir;
    st   = !s.rst && s.idv && !fire && !s.redir;
    e = {iv, idr, fl, st, CW'(mcnt), mb};
  endtask

  task automatic model_update(input stim_t s, input bit fire);
    int prev;
    bit marks;
    if (s.rst) begin
      mb = '0; mcnt = 0; mdrain = 0; mflush = 0;
      return;
    end
`ifdef ID_ISSUE_BYPASS_EN
    marks = s.ld;
`else
    marks = 1'b1;
`endif
    if (s.wbv && s.wbe && s.wba != 0) mb[s.wba] = 1'b0;
    if (fire && s.rde && s.rda != 0 && marks) mb[s.rda] = 1'b1;
    prev = mcnt;
    mcnt = mcnt + (fire ? 1 : 0) - ((s.wbv && prev > 0) ? 1 : 0);
    if (s.redir) begin
      mflush = 1; mdrain = 0;
    end else if (mflush) begin
      mflush = 0;
    end else if (mdrain) begin
      if (prev == 0) mdrain = 0;
    end else if ((fire && s.ser) || (s.idv && s.ser && prev != 0)) begin
      mdrain = 1;
    end
  endtask

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got iv/idr/fl/st=%b inflight=%0d busy=%h, expected iv/idr/fl/st=%b inflight=%0d busy=%h",
               name, act[38:35], act[34:32], act[31:0], exp[38:35], exp[34:32], exp[31:0]);
    end
  endtask

  // One clock cycle: drive, settle, compare against the model (and an
  // optional table expectation), then advance the model at the edge.
  task automatic cycle(input stim_t s, input bit use_tab, input logic [38:0] texp,
                       input string name);
    logic [38:0] e, act;
    bit fire;
    drive(s);
    #2;
    model_eval(s, e, fire);
    act = {issue_valid, id_ready, if_flush, stall, inflight, busy_vec};
    check({"model ", name}, act, e);
    if (use_tab) check({"table ", name}, act, texp);
    @(posedge clk);
    model_update(s, fire);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.idv = 0; s.exr = 1; s.rs1e = 0; s.rs2e = 0; s.rde = 0; s.ld = 0;
    s.ser = 0; s.redir = 0; s.wbv = 0; s.wbe = 0;
    s.rs1a = 0; s.rs2a = 0; s.rda = 0; s.wba = 0;
    return s;
  endfunction

  task automatic drain_all();
    stim_t s;
    int guard = 0;
    while (mcnt > 0 && guard < 20) begin
      s = idle();
      s.wbv = 1; s.wbe = 1; s.wba = 0;
      for (int i = 31; i > 0; i--) if (mb[i]) s.wba = 5'(i);
      cycle(s, 0, '0, "drain");
      guard++;
    end
  endtask

  row_t tab[$];

  initial begin : main
    stim_t s;
    int waited;
    int exp_wait;

    // Directed table: loads only, so expectations hold in both builds.
    //                rst idv rs1 rs2 rd ser red wbv wba  iv idr fl st inf busy
    tab.push_back(mk(1, 1, 0, 0, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 5, 0, 6, 0, 0, 0, 0,   0, 0, 0, 1, 1, 32'h20));
    tab.push_back(mk(0, 1, 5, 0, 6, 0, 0, 1, 5,   0, 0, 0, 1, 1, 32'h20));
    tab.push_back(mk(0, 1, 5, 0, 6, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6,   0, 1, 0, 0, 1, 32'h40));
    tab.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 0,   1, 1, 0, 0, 1, 32'h2));
    tab.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0, 0,   1, 1, 0, 0, 2, 32'h6));
    tab.push_back(mk(0, 1, 0, 0, 4, 0, 0, 0, 0,   1, 1, 0, 0, 3, 32'hE));
    tab.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, 0,   0, 0, 0, 1, 4, 32'h1E));
    tab.push_back(mk(0, 1, 0, 0, 7, 0, 0, 1, 1,   0, 0, 0, 1, 4, 32'h1E));
    tab.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, 0,   1, 1, 0, 0, 3, 32'h1C));
    tab.push_back(mk(0, 1, 2, 0, 8, 0, 1, 0, 0,   0, 1, 1, 0, 4, 32'h9C));
    tab.push_back(mk(0, 1, 0, 0, 8, 0, 0, 1, 2,   0, 0, 0, 1, 4, 32'h9C));
    tab.push_back(mk(0, 1, 0, 0, 8, 0, 0, 0, 0,   1, 1, 0, 0, 3, 32'h98));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3,   0, 1, 0, 0, 4, 32'h198));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4,   0, 1, 0, 0, 3, 32'h190));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 1, 0, 0, 2, 32'h180));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8,   0, 1, 0, 0, 1, 32'h100));
    tab.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 0,   1, 1, 0, 0, 1, 32'h2));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 2, 32'h6));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 1,   0, 0, 0, 1, 2, 32'h6));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 1, 2,   0, 0, 0, 1, 1, 32'h4));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0, 0,   0, 0, 0, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1, 0,   0, 0, 0, 1, 1, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0, 0,   0, 0, 0, 1, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 3, 0, 0, 0, 0,   1, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 1, 0, 0, 7, 0, 0, 1, 3,   1, 1, 0, 0, 1, 32'h8));
    tab.push_back(mk(0, 1, 0, 0, 9, 0, 0, 1, 7,   1, 1, 0, 0, 1, 32'h80));
    tab.push_back(mk(0, 1, 0, 0, 7, 0, 0, 1, 7,   1, 1, 0, 0, 1, 32'h200));
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 32'h280));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 2, 32'h280));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 1, 0, 0, 1, 32'h280));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 1, 0, 0, 0, 32'h80));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5,   0, 1, 0, 0, 0, 32'h0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 32'h0));

    // Reset preamble
    s = idle(); s.rst = 1;
    drive(s);
    repeat (2) @(posedge clk);
    model_update(s, 0);
    #1;

    foreach (tab[i]) cycle(tab[i].s, 1, tab[i].exp, $sformatf("row %0d", i));

    // ALU writer followed by a dependent ALU op. With forwarding it issues
    // at once. Without forwarding it waits for x5's writeback (third cycle)
    // and issues on the next one.
`ifdef ID_ISSUE_BYPASS_EN
    exp_wait = 0;
`else
    exp_wait = 3;
`endif
    s = idle(); s.idv = 1; s.rde = 1; s.rda = 5; s.rs1e = 1;
    cycle(s, 0, '0, "addi x5");
    waited = 0;
    for (int k = 0; k < 8; k++) begin
      s = idle(); s.idv = 1; s.rs1e = 1; s.rs1a = 5; s.rs2e = 1; s.rs2a = 1;
      s.rde = 1; s.rda = 6;
      if (k == 2) begin s.wbv = 1; s.wbe = 1; s.wba = 5; end
      drive(s);
      #1;
      if (issue_valid === 1'b1) break;
      #1;
      s = s;
      cycle(s, 0, '0, "add x6 wait");
      waited++;
    end
    nvec++;
    if (waited != exp_wait) begin
      nerr++;
      $display("FAIL alu-dep wait: got %0d cycles, expected %0d", waited, exp_wait);
    end
    cycle(s, 0, '0, "add x6 issue");
    drain_all();

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      s.rst   = ($urandom_range(0, 299) == 0);
      s.idv   = ($urandom_range(0, 3) != 0);
      s.exr   = ($urandom_range(0, 3) != 0);
      s.rs1e  = $urandom_range(0, 1); s.rs1a = 5'($urandom_range(0, 7));
      s.rs2e  = $urandom_range(0, 1); s.rs2a = 5'($urandom_range(0, 7));
      s.rde   = $urandom_range(0, 1); s.rda  = 5'($urandom_range(0, 7));
      s.ld    = $urandom_range(0, 1);
      s.ser   = ($urandom_range(0, 9) == 0);
      s.redir = ($urandom_range(0, 11) == 0);
      s.wbv   = (mcnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      s.wbe   = ($urandom_range(0, 3) != 0);
      s.wba   = 5'($urandom_range(0, 7));
      cycle(s, 0, '0, $sformatf("rand %0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_id_issue_ctrl
`default_nettype wire
